reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter N_SRC, default 2: number of external reset request inputs.
REQ-002 Parameter N_OUT, default 3: number of sequenced reset outputs.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser depth per request input, minimum 2.
REQ-004 Parameter DEBOUNCE_CNT, default 4: stable cycles required before a filtered request changes; 0 bypasses the filter.
REQ-005 Parameter STRETCH_CYCLES, default 16: request-free cycles required before release starts, minimum 1.
REQ-006 Parameter STAGE_GAP, default 8: cycles between successive output releases, minimum 1.
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 sys_rst  input  1  reset, synchronous, active-high.
REQ-009 rst_req  input  N_SRC  asynchronous active-high reset requests (buttons, watchdog, host).
REQ-010 src_en  input  N_SRC  per-source enable; a disabled source is ignored after filtering.
REQ-011 soft_rst  input  1  synchronous single-cycle software reset request.
REQ-012 cause_clr  input  1  synchronous clear of the cause register.
REQ-013 rstn_out  output  N_OUT  registered active-low resets; bit 0 is released first.
REQ-014 busy  output  1  high whenever any rstn_out bit is low.
REQ-015 cause  output  N_SRC+1  sticky reset-cause bits; bit N_SRC = soft_rst.

Function
REQ-016 Each rst_req bit shall pass through a SYNC_STAGES flop synchroniser, then a debounce filter whose output flips only after the synchronised input has differed from it for DEBOUNCE_CNT consecutive cycles.
REQ-017 Internal request = OR over i of (filtered[i] AND src_en[i]), OR soft_rst.
REQ-018 FSM states: HOLD, RELEASE, RUN; reset state is HOLD.
REQ-019 HOLD: all rstn_out low; stretch counter counts request-free cycles and restarts on any request; after STRETCH_CYCLES request-free cycles, go to RELEASE.
REQ-020 RELEASE: rstn_out[0] goes high on the first RELEASE cycle; rstn_out[k] goes high STAGE_GAP cycles after rstn_out[k-1]; after rstn_out[N_OUT-1] goes high, go to RUN.
REQ-021 RUN: all rstn_out high, busy low.
REQ-022 A request in RELEASE or RUN shall drive all rstn_out low on the next edge and return to HOLD with the stretch counter cleared.
REQ-023 Latency from a clean rst_req rising edge to rstn_out low, in RUN: SYNC_STAGES+DEBOUNCE_CNT+1 cycles.
REQ-024 Latency from a soft_rst pulse to rstn_out low: 1 cycle.
REQ-025 cause[i] shall set on any cycle where filtered[i] AND src_en[i] is high; cause[N_SRC] shall set on soft_rst.
REQ-026 cause_clr shall clear all cause bits; a set and a clear in the same cycle leave that bit set.
REQ-027 Glitches shorter than DEBOUNCE_CNT cycles after synchronisation shall produce no reset and no cause bit.
REQ-028 busy shall be combinationally equal to NOT(AND of rstn_out), with no extra cycle of lag.

Reset
REQ-029 sys_rst high: state HOLD, rstn_out all 0, busy 1, cause all 0, synchronisers and filters 0, counters 0; this takes effect on the next clk edge, including mid-RELEASE.
REQ-030 Stretch timing starts on the first cycle with sys_rst low.

Structure
REQ-031 Package reset_seq_pkg shall hold the FSM state enum and the default parameter constants.
REQ-032 Sub-module reset_debounce (synchroniser plus filter, one bit) shall be instantiated N_SRC times.

Verification (defaults: N_SRC=2, N_OUT=3, SYNC=2, DEBOUNCE=4, STRETCH=16, GAP=8)
REQ-033 sys_rst high 3 cycles, then low, no requests: rstn_out=000 and busy=1; rstn_out[0] rises 16 cycles after release, [1] at 24, [2] at 32; busy falls at 32.
REQ-034 In RUN, rst_req[0] high 3 cycles: no reset, cause=000. rst_req[0] high 10 cycles: rstn_out=000 7 cycles after the rising edge, cause=001.
REQ-035 src_en[1]=0, rst_req[1] high 50 cycles: rstn_out stays 111, cause unchanged.
REQ-036 soft_rst pulse in RELEASE right after rstn_out[0] rises: rstn_out=000 next cycle, full 16-cycle stretch repeats, cause[2]=1.
REQ-037 cause_clr in the same cycle as a new filtered rst_req[1]: cause[1] remains 1; a later lone cause_clr gives cause=000.
REQ-038 sys_rst pulse while rstn_out=011 in RELEASE: rstn_out=000 and cause=000 next edge; sequence restarts per REQ-033.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and default
// parameter values.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  localparam int DEF_N_SRC          = 2;
  localparam int DEF_N_OUT          = 3;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_DEBOUNCE_CNT   = 4;
  localparam int DEF_STRETCH_CYCLES = 16;
  localparam int DEF_STAGE_GAP      = 8;

endpackage

// File: rtl/reset_debounce.sv
// One-bit synchroniser followed by a debounce filter; the filtered output
// flips only after the synchronised input has disagreed for DEBOUNCE_CNT cycles.
module reset_debounce
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
  input  logic clk,
  input  logic sys_rst,
  input  logic req_async,
  output logic filt
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_s;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], req_async};
  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (sys_rst) sync_q <= '0;
    else         sync_q <= sync_d;
  end

  if (DEBOUNCE_CNT == 0) begin : g_bypass
    assign filt = sync_s;
  end else begin : g_filt
    localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;

    always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      // Counter only runs while the input disagrees; any agreement restarts it.
      if (sync_s != filt_q) begin
        if (cnt_q == CW'(DEBOUNCE_CNT - 1)) filt_d = sync_s;
        else                                cnt_d  = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (sys_rst) begin
        cnt_q  <= '0;
        filt_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        filt_q <= filt_d;
      end
    end

    assign filt = filt_q;
  end

endmodule

// File: rtl/reset_sequencer.sv
// Collects filtered reset requests, stretches them, then releases the active-low
// reset outputs one at a time, bit 0 first, recording which sources fired.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_SRC          = DEF_N_SRC,
  parameter int N_OUT          = DEF_N_OUT,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CNT   = DEF_DEBOUNCE_CNT,
  parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
  parameter int STAGE_GAP      = DEF_STAGE_GAP
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic [N_SRC-1:0] rst_req,
  input  logic [N_SRC-1:0] src_en,
  input  logic             soft_rst,
  input  logic             cause_clr,
  output logic [N_OUT-1:0] rstn_out,
  output logic             busy,
  output logic [N_SRC:0]   cause
);

  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);

  logic [N_SRC-1:0] filt;
  logic             req;

  state_e           state_q, state_d;
  logic [SW-1:0]    stretch_q, stretch_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [N_OUT-1:0] rstn_q, rstn_d;
  logic [N_SRC:0]   cause_q, cause_d;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    reset_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_deb (
      .clk      (clk),
      .sys_rst  (sys_rst),
      .req_async(rst_req[i]),
      .filt     (filt[i])
    );
  end

  assign req = (|(filt & src_en)) | soft_rst;

  always_comb begin
    state_d   = state_q;
    stretch_d = stretch_q;
    gap_d     = gap_q;
    rstn_d    = rstn_q;

    // Set wins over clear so a cause arriving with cause_clr is not lost.
    for (int i = 0; i < N_SRC; i++)
      cause_d[i] = (cause_q[i] & ~cause_clr) | (filt[i] & src_en[i]);
    cause_d[N_SRC] = (cause_q[N_SRC] & ~cause_clr) | soft_rst;

    case (state_q)
      ST_HOLD: begin
        rstn_d = '0;
        gap_d  = '0;
        if (req) begin
          stretch_d = '0;
        end else if (stretch_q == SW'(STRETCH_CYCLES - 1)) begin
          stretch_d = '0;
          rstn_d    = N_OUT'(1);
          state_d   = (&rstn_d) ? ST_RUN : ST_RELEASE;
        end else begin
          stretch_d = stretch_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (req) begin
          rstn_d    = '0;
          stretch_d = '0;
          gap_d     = '0;
          state_d   = ST_HOLD;
        end else if (gap_q == GW'(STAGE_GAP - 1)) begin
          // Outputs form a thermometer code; shift in the next released bit.
          gap_d  = '0;
          rstn_d = (rstn_q << 1) | N_OUT'(1);
          if (&rstn_d) state_d = ST_RUN;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_RUN: begin
        rstn_d = '1;
        if (req) begin
          rstn_d    = '0;
          stretch_d = '0;
          gap_d     = '0;
          state_d   = ST_HOLD;
        end
      end
      default: begin
        rstn_d    = '0;
        stretch_d = '0;
        gap_d     = '0;
        state_d   = ST_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q   <= ST_HOLD;
      stretch_q <= '0;
      gap_q     <= '0;
      rstn_q    <= '0;
      cause_q   <= '0;
    end else begin
      state_q   <= state_d;
      stretch_q <= stretch_d;
      gap_q     <= gap_d;
      rstn_q    <= rstn_d;
      cause_q   <= cause_d;
    end
  end

  assign rstn_out = rstn_q;
  assign busy     = ~(&rstn_q);
  assign cause    = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters; expected values are
// hand-derived edge counts from the request or release edge.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic [1:0] rst_req;
  logic [1:0] src_en;
  logic       soft_rst;
  logic       cause_clr;
  logic [2:0] rstn_out;
  logic       busy;
  logic [2:0] cause;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .N_SRC(2), .N_OUT(3), .SYNC_STAGES(2), .DEBOUNCE_CNT(4),
    .STRETCH_CYCLES(16), .STAGE_GAP(8)
  ) dut (
    .clk      (clk),
    .sys_rst  (sys_rst),
    .rst_req  (rst_req),
    .src_en   (src_en),
    .soft_rst (soft_rst),
    .cause_clr(cause_clr),
    .rstn_out (rstn_out),
    .busy     (busy),
    .cause    (cause)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    sys_rst = 1'b1; rst_req = 2'b00; src_en = 2'b11; soft_rst = 1'b0; cause_clr = 1'b0;

    // Power-on reset and first release sequence.
    tick(3);
    chk("rst_rstn",  8'(rstn_out), 8'h0);
    chk("rst_busy",  8'(busy),     8'h1);
    chk("rst_cause", 8'(cause),    8'h0);
    sys_rst = 1'b0;
    tick(15); chk("por_e15",  8'(rstn_out), 8'h0);
    tick(1);  chk("por_e16",  8'(rstn_out), 8'h1);
              chk("por_busy16", 8'(busy),   8'h1);
    tick(7);  chk("por_e23",  8'(rstn_out), 8'h1);
    tick(1);  chk("por_e24",  8'(rstn_out), 8'h3);
    tick(7);  chk("por_e31",  8'(rstn_out), 8'h3);
              chk("por_busy31", 8'(busy),   8'h1);
    tick(1);  chk("por_e32",  8'(rstn_out), 8'h7);
              chk("por_busy32", 8'(busy),   8'h0);

    // Three-cycle glitch on source 0 is filtered out.
    rst_req = 2'b01; tick(3); rst_req = 2'b00;
    tick(10);
    chk("glitch_rstn",  8'(rstn_out), 8'h7);
    chk("glitch_cause", 8'(cause),    8'h0);

    // Ten-cycle request on source 0: reset 7 edges after the rising edge.
    rst_req = 2'b01;
    tick(6); chk("req0_e6", 8'(rstn_out), 8'h7);
    tick(1); chk("req0_e7", 8'(rstn_out), 8'h0);
             chk("req0_cause", 8'(cause), 8'h1);
             chk("req0_busy",  8'(busy),  8'h1);
    tick(3); rst_req = 2'b00;
    // Filter drops at edge 16, so release lands at edge 32.
    tick(21); chk("req0_e31", 8'(rstn_out), 8'h0);
    tick(1);  chk("req0_e32", 8'(rstn_out), 8'h1);
    tick(16); chk("req0_run", 8'(rstn_out), 8'h7);
              chk("req0_cause_run", 8'(cause), 8'h1);
    cause_clr = 1'b1; tick(1); cause_clr = 1'b0;
    chk("clr1_cause", 8'(cause), 8'h0);

    // Disabled source 1 is ignored even when held for 50 cycles.
    src_en = 2'b01; rst_req = 2'b10;
    tick(50);
    chk("dis_rstn",  8'(rstn_out), 8'h7);
    chk("dis_cause", 8'(cause),    8'h0);
    rst_req = 2'b00; tick(10); src_en = 2'b11;
    tick(1);
    chk("dis_after", 8'(rstn_out), 8'h7);

    // cause_clr coinciding with a new filtered request keeps the bit.
    rst_req = 2'b10;
    tick(6); cause_clr = 1'b1;
    tick(1); cause_clr = 1'b0;
    chk("setclr_cause", 8'(cause),    8'h2);
    chk("setclr_rstn",  8'(rstn_out), 8'h0);
    rst_req = 2'b00;
    tick(12); cause_clr = 1'b1;
    tick(1);  cause_clr = 1'b0;
    chk("lone_clr", 8'(cause), 8'h0);

    // Soft reset right after bit 0 releases restarts the full stretch.
    tick(9); chk("sr_rel0", 8'(rstn_out), 8'h1);
    soft_rst = 1'b1; tick(1); soft_rst = 1'b0;
    chk("sr_rstn",  8'(rstn_out), 8'h0);
    chk("sr_cause", 8'(cause),    8'h4);
    tick(15); chk("sr_e15", 8'(rstn_out), 8'h0);
    tick(1);  chk("sr_e16", 8'(rstn_out), 8'h1);

    // sys_rst in mid-release clears everything on the next edge.
    tick(8); chk("mid_011", 8'(rstn_out), 8'h3);
    sys_rst = 1'b1; tick(1); sys_rst = 1'b0;
    chk("mid_rstn",  8'(rstn_out), 8'h0);
    chk("mid_cause", 8'(cause),    8'h0);
    chk("mid_busy",  8'(busy),     8'h1);
    tick(15); chk("mid_e15", 8'(rstn_out), 8'h0);
    tick(1);  chk("mid_e16", 8'(rstn_out), 8'h1);
    tick(8);  chk("mid_e24", 8'(rstn_out), 8'h3);
    tick(8);  chk("mid_e32", 8'(rstn_out), 8'h7);
              chk("mid_busy32", 8'(busy),  8'h0);

    // Exactly DEBOUNCE_CNT cycles of request is enough to reset.
    rst_req = 2'b01; tick(4); rst_req = 2'b00;
    tick(2); chk("edge4_e6", 8'(rstn_out), 8'h7);
    tick(1); chk("edge4_e7", 8'(rstn_out), 8'h0);
             chk("edge4_cause", 8'(cause), 8'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
